// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch redirect/flush and memory-wait freeze control.
// Define HAZARD_PERF_EN to add saturating stall/redirect event counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int RA_W         = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid_i,
    input  logic            id_uses_rs1_i,
    input  logic            id_uses_rs2_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_load_i,
    input  logic            ex_branch_taken_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            mem_busy_i,
    output logic            stall_o,
    output logic            pc_sel_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            bubble_ex_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o,
`endif
    output logic [1:0]      state_o
);
    typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, FLUSH = 2'd2} state_e;
    localparam logic [1:0] FC = 2'(FLUSH_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hazard, redirect, in_run, in_flush;

    assign hazard   = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != '0) &
                      ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
    assign redirect = ex_valid_i & ex_branch_taken_i & ~mem_busy_i;
    assign in_run   = state_q == RUN;
    assign in_flush = state_q == FLUSH;

    assign stall_o     = mem_busy_i | (hazard & ~redirect & in_run);
    assign pc_sel_o    = redirect;
    assign flush_if_o  = redirect | (in_flush & ~mem_busy_i);
    assign flush_id_o  = flush_if_o;
    assign bubble_ex_o = ~mem_busy_i & (redirect | in_flush | (hazard & in_run));
    assign state_o     = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                    cnt_d   = FC;
                end else if (mem_busy_i) begin
                    state_d = MEMWAIT;
                end
            end
            MEMWAIT: state_d = mem_busy_i ? MEMWAIT : RUN;
            FLUSH: begin
                // a fresh redirect restarts the flush window; memory stalls freeze it
                if (redirect) begin
                    cnt_d = FC;
                end else if (!mem_busy_i) begin
                    cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                    state_d = (cnt_q <= 2'd1) ? RUN : FLUSH;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;
    localparam int FC   = 2;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid, id_uses_rs1, id_uses_rs2;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
    logic            ex_valid, ex_is_load, ex_branch_taken, mem_busy;
    logic            stall, pc_sel, flush_if, flush_id, bubble_ex;
    logic [1:0]      state;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // reference model: mode 0=running, 1=waiting on memory, 2=flushing with m_left cycles to go
    int     m_state = 0;
    int     m_left = 0;
    longint m_stalls = 0;
    longint m_flushes = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_branch_taken_i(ex_branch_taken),
        .ex_rd_i(ex_rd), .mem_busy_i(mem_busy),
        .stall_o(stall), .pc_sel_o(pc_sel), .flush_if_o(flush_if), .flush_id_o(flush_id),
        .bubble_ex_o(bubble_ex),
`ifdef HAZARD_PERF_EN
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
        .state_o(state)
    );

    function automatic bit f_hz();
        return id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction
    function automatic bit f_rd();
        return ex_valid && ex_branch_taken && !mem_busy;
    endfunction
    function automatic bit f_stall();
        return mem_busy || (f_hz() && !f_rd() && m_state == 0);
    endfunction
    function automatic bit f_flush();
        return f_rd() || (m_state == 2 && !mem_busy);
    endfunction
    function automatic bit f_bub();
        return !mem_busy && (f_rd() || m_state == 2 || (f_hz() && m_state == 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (f_stall()) m_stalls++;
            if (f_rd()) m_flushes++;
            if (m_state == 0) begin
                if (f_rd()) begin m_state = 2; m_left = FC; end
                else if (mem_busy) m_state = 1;
            end else if (m_state == 1) begin
                if (!mem_busy) m_state = 0;
            end else if (!mem_busy) begin
                if (f_rd()) m_left = FC;
                else begin
                    m_left--;
                    if (m_left == 0) m_state = 0;
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic u1, input logic u2,
                         input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2,
                         input logic ev, input logic ld, input logic bt,
                         input logic [RA_W-1:0] rd, input logic mb);
        @(negedge clk);
        id_valid = iv; id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1 = r1; id_rs2 = r2;
        ex_valid = ev; ex_is_load = ld; ex_branch_taken = bt; ex_rd = rd; mem_busy = mb;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({stall, pc_sel, flush_if, flush_id, bubble_ex, state} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000", {stall, pc_sel, flush_if, flush_id, bubble_ex, state});
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_release_state got=%0d exp=0", state); end
    endtask

    task automatic test_load_use();
        idle();
        drive(1, 1, 0, 5, 0, 1, 1, 0, 5, 0);
        checks++;
        if (stall !== 1'b1 || bubble_ex !== 1'b1 || state !== 2'd0) begin
            failures++;
            $display("FAIL load_use got stall=%b bubble=%b state=%0d exp 1 1 0", stall, bubble_ex, state);
        end
        idle();
        checks++;
        if (stall !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL load_use_after got stall=%b state=%0d exp 0 0", stall, state);
        end
        drive(1, 0, 1, 0, 9, 1, 1, 0, 9, 0);
        checks++;
        if (stall !== 1'b1 || bubble_ex !== 1'b1) begin
            failures++;
            $display("FAIL load_use_rs2 got stall=%b bubble=%b exp 1 1", stall, bubble_ex);
        end
    endtask

    task automatic test_x0_load();
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (stall !== 1'b0 || bubble_ex !== 1'b0) begin
            failures++;
            $display("FAIL x0_load got stall=%b bubble=%b exp 0 0", stall, bubble_ex);
        end
        idle();
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        checks++;
        if (pc_sel !== 1'b1 || flush_if !== 1'b1 || flush_id !== 1'b1 || bubble_ex !== 1'b1) begin
            failures++;
            $display("FAIL branch_redirect got pc_sel=%b flush_if=%b flush_id=%b bubble=%b exp 1 1 1 1",
                     pc_sel, flush_if, flush_id, bubble_ex);
        end
        for (int i = 0; i < FC; i++) begin
            idle();
            checks++;
            if (state !== 2'd2 || flush_if !== 1'b1 || pc_sel !== 1'b0) begin
                failures++;
                $display("FAIL branch_flush%0d got state=%0d flush_if=%b pc_sel=%b exp 2 1 0", i, state, flush_if, pc_sel);
            end
        end
        idle();
        checks++;
        if (state !== 2'd0 || flush_if !== 1'b0) begin
            failures++;
            $display("FAIL branch_done got state=%0d flush_if=%b exp 0 0", state, flush_if);
        end
    endtask

    task automatic test_memwait();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (stall !== 1'b1 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                failures++;
                $display("FAIL memwait%0d got stall=%b state=%0d exp 1 %0d", i, stall, state, (i == 0) ? 0 : 1);
            end
        end
        idle();
        checks++;
        if (stall !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL memwait_drop got stall=%b state=%0d exp 0 1", stall, state);
        end
        idle();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL memwait_exit got state=%0d exp 0", state); end
    endtask

    task automatic test_branch_during_busy();
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        checks++;
        if (pc_sel !== 1'b0 || flush_if !== 1'b0 || bubble_ex !== 1'b0) begin
            failures++;
            $display("FAIL branch_busy got pc_sel=%b flush_if=%b bubble=%b exp 0 0 0", pc_sel, flush_if, bubble_ex);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        checks++;
        if (pc_sel !== 1'b1 || flush_if !== 1'b1) begin
            failures++;
            $display("FAIL branch_busy_release got pc_sel=%b flush_if=%b exp 1 1", pc_sel, flush_if);
        end
        idle();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL branch_busy_state got state=%0d exp 0", state); end
    endtask

    task automatic test_hazard_vs_redirect();
        drive(1, 1, 0, 7, 0, 1, 1, 1, 7, 0);
        checks++;
        if (stall !== 1'b0 || pc_sel !== 1'b1) begin
            failures++;
            $display("FAIL hazard_vs_redirect got stall=%b pc_sel=%b exp 0 1", stall, pc_sel);
        end
        repeat (FC + 1) idle();
    endtask

    task automatic test_reset_mid_flush();
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        idle();
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL midflush_pre got state=%0d exp 2", state); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || flush_if !== 1'b0) begin
            failures++;
            $display("FAIL midflush_async got state=%0d flush_if=%b exp 0 0", state, flush_if);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midflush_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL midflush_resume got state=%0d exp 0", state); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  RA_W'($urandom_range(0, 3)), RA_W'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                  RA_W'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
            checks++;
            if (stall !== f_stall()) begin failures++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, stall, f_stall()); end
            checks++;
            if (pc_sel !== f_rd()) begin failures++; $display("FAIL rand_pc_sel cyc=%0d got=%b exp=%b", c, pc_sel, f_rd()); end
            checks++;
            if (flush_if !== f_flush() || flush_id !== f_flush()) begin
                failures++;
                $display("FAIL rand_flush cyc=%0d got=%b%b exp=%b", c, flush_if, flush_id, f_flush());
            end
            checks++;
            if (bubble_ex !== f_bub()) begin failures++; $display("FAIL rand_bubble cyc=%0d got=%b exp=%b", c, bubble_ex, f_bub()); end
            checks++;
            if (state !== 2'(m_state)) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", c, state, m_state); end
`ifdef HAZARD_PERF_EN
            checks++;
            if (stall_cnt !== 32'(m_stalls) || flush_cnt !== 32'(m_flushes)) begin
                failures++;
                $display("FAIL rand_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, m_stalls, m_flushes);
            end
`endif
        end
    endtask

    initial begin
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_branch_taken = 0; ex_rd = 0; mem_busy = 0;
        test_reset();
        test_load_use();
        test_x0_load();
        test_branch();
        test_memwait();
        test_branch_during_busy();
        test_hazard_vs_redirect();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, meaning: cycles in FLUSH after a redirect; legal range 1-3.
REQ-002 Parameter RA_W, default 5, meaning: register-address width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid, id_uses_rs1, id_uses_rs2  in  1 each  decode-stage instruction valid and source-operand-used flags.
REQ-006 id_rs1, id_rs2  in  RA_W each  decode-stage source register addresses.
REQ-007 ex_valid, ex_is_load, ex_branch_taken  in  1 each  execute-stage valid, load flag and comparison-taken flag.
REQ-008 ex_rd  in  RA_W  execute-stage destination register.
REQ-009 mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-010 stall  out  1  drives the fetch-stage stall input.
REQ-011 pc_sel  out  1  1 = fetch takes the ALU target PC.
REQ-012 flush_if, flush_id, bubble_ex  out  1 each  kill the IF/ID contents; insert a NOP into EX.
REQ-013 state  out  2  FSM state: RUN=0, MEMWAIT=1, FLUSH=2 (3 unused).

Function
REQ-014 hazard = id_valid & ex_valid & ex_is_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)); combinational.
REQ-015 redirect = ex_valid & ex_branch_taken & !mem_busy; combinational.
REQ-016 All outputs are combinational from the current state and inputs (Mealy), with zero-cycle latency.
REQ-017 stall = mem_busy | (hazard & !redirect & state == RUN).
REQ-018 pc_sel = redirect.
REQ-019 flush_if = flush_id = redirect | (state == FLUSH & !mem_busy).
REQ-020 bubble_ex = !mem_busy & (redirect | state == FLUSH | (hazard & state == RUN)).
REQ-021 Transitions from RUN follow this priority: redirect goes to FLUSH and loads counter = FLUSH_CYCLES; else mem_busy goes to MEMWAIT; else the FSM stays in RUN.
REQ-022 In MEMWAIT, the FSM stays while mem_busy = 1, and leaves for RUN on the first edge where mem_busy = 0.
REQ-023 In FLUSH, mem_busy = 1 freezes the counter and holds the state.
REQ-024 In FLUSH, redirect reloads counter = FLUSH_CYCLES and holds the state.
REQ-025 Otherwise in FLUSH, the counter decrements; the FSM returns to RUN on the edge where the counter goes 1 -> 0.
REQ-026 A load-use hazard produces exactly one stall cycle; no state is held for it, because the load advances and the hazard clears.
REQ-027 A hazard and a redirect in the same cycle resolve to the redirect: stall = 0, pc_sel = 1.
REQ-028 An ex_branch_taken held during mem_busy produces no redirect; it takes effect on the first cycle where mem_busy = 0.
REQ-029 The counter is 2 bits wide and never wraps below 0.

Reset
REQ-030 rst_n = 0 forces state = RUN and counter = 0 immediately, independent of clk.
REQ-031 With all inputs at 0 during reset, every output reads 0.
REQ-032 Reset asserted mid-FLUSH or mid-MEMWAIT abandons that state; the FSM resumes in RUN after the first rising edge with rst_n = 1.

Configuration
REQ-033 Macro HAZARD_PERF_EN defined adds two outputs: stall_cnt[31:0] and flush_cnt[31:0].
REQ-034 stall_cnt increments on each edge where stall = 1; flush_cnt increments on each edge where redirect = 1.
REQ-035 Both counters saturate at 0xFFFFFFFF and reset to 0.
REQ-036 HAZARD_PERF_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

Verification
REQ-037 Load-use: ex_valid=1, ex_is_load=1, ex_rd=5; id_valid=1, id_uses_rs1=1, id_rs1=5 for one cycle -> stall=1 and bubble_ex=1 for that cycle; state stays 0.
REQ-038 x0 load: same stimulus with ex_rd=0 and id_rs1=0 -> stall=0 and bubble_ex=0.
REQ-039 Taken branch, FLUSH_CYCLES=2: ex_valid=1, ex_branch_taken=1 for one cycle -> pc_sel=1 and flush_if=1 that cycle; state=2 for the next 2 cycles with flush_if=1; then state=0.
REQ-040 mem_busy=1 for 3 cycles from RUN -> stall=1 for those 3 cycles and state=1 on cycles 2-3; state=0 on the edge after busy drops.
REQ-041 Branch taken with mem_busy=1 -> pc_sel=0; when busy drops, pc_sel=1 in that same cycle.
REQ-042 rst_n pulsed low in FLUSH, with HAZARD_PERF_EN defined -> state=0 immediately; stall_cnt=0 and flush_cnt=0.
